// File: rtl/outagu_if.sv
// Result-vector handshake and data-memory write port of the output address generator.
// master = outagu side, slave = producer / memory side.
interface outagu_if #(
    parameter int unsigned BPREC   = 6,
    parameter int unsigned BDBANKA = 15
);
    logic               in_valid;
    logic               in_ready;
    logic               wr_ready;
    logic               wr_en;
    logic [BDBANKA-1:0] wr_addr;
    logic [BPREC-1:0]   wr_plane;
    logic               omsb;
    logic               olsb;

    modport master (
        input  in_valid, wr_ready,
        output in_ready, wr_en, wr_addr, wr_plane, omsb, olsb
    );

    modport slave (
        output in_valid, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_plane, omsb, olsb
    );
endinterface

// File: rtl/outagu.sv
// Output address generator: bit-serial write-back addresses, MSB plane first, 3-level loop.
// Define OUTAGU_BACK2BACK_EN to accept the next vector during the last-plane grant (zero bubble).
module outagu #(
    parameter int unsigned BPREC    = 6,
    parameter int unsigned BDBANKA  = 15,
    parameter int unsigned BWLENGTH = 8
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                start,
    input  logic [BPREC-1:0]    oprecision,
    input  logic [BDBANKA-1:0]  obaseaddr,
    input  logic [BDBANKA-1:0]  ostride0,
    input  logic [BDBANKA-1:0]  ostride1,
    input  logic [BWLENGTH-1:0] olength0,
    input  logic [BWLENGTH-1:0] olength1,
    input  logic [BWLENGTH-1:0] olength2,
    outagu_if.master            bus,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {StIdle, StWait, StWrite} state_t;

    state_t              state_q, state_d;
    logic [BPREC-1:0]    prec_q, prec_d;
    logic [BDBANKA-1:0]  base_q, base_d, stride0_q, stride0_d, stride1_q, stride1_d;
    logic [BWLENGTH-1:0] len0_q, len0_d, len1_q, len1_d, len2_q, len2_d;
    logic [BWLENGTH-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
    logic [BDBANKA-1:0]  pos_q, pos_d;
    logic [BPREC-1:0]    plane_q, plane_d;
    logic                done_q, done_d;

    logic last_plane, complete, grant_last;

    always_comb begin
        last_plane = (plane_q == prec_q - 1'b1);
        complete   = (c0_q == len0_q) && (c1_q == len1_q) && (c2_q == len2_q);
        grant_last = (state_q == StWrite) && bus.wr_ready && last_plane;
    end

    // A start pulse overrides any acceptance, so in_ready is masked while it is high.
`ifdef OUTAGU_BACK2BACK_EN
    assign bus.in_ready = !start && ((state_q == StWait) || (grant_last && !complete));
`else
    assign bus.in_ready = !start && (state_q == StWait);
`endif

    always_comb begin
        state_d   = state_q;
        prec_d    = prec_q;
        base_d    = base_q;
        stride0_d = stride0_q;
        stride1_d = stride1_q;
        len0_d    = len0_q;
        len1_d    = len1_q;
        len2_d    = len2_q;
        c0_d      = c0_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        pos_d     = pos_q;
        plane_d   = plane_q;
        done_d    = 1'b0;

        if (start) begin
            prec_d    = (oprecision == '0) ? BPREC'(1) : oprecision;
            base_d    = obaseaddr;
            stride0_d = ostride0;
            stride1_d = ostride1;
            len0_d    = olength0;
            len1_d    = olength1;
            len2_d    = olength2;
            c0_d      = '0;
            c1_d      = '0;
            c2_d      = '0;
            pos_d     = '0;
            plane_d   = '0;
            state_d   = StWait;
        end else begin
            unique case (state_q)
                StIdle: ;
                StWait: begin
                    if (bus.in_valid) begin
                        state_d = StWrite;
                        plane_d = '0;
                    end
                end
                StWrite: begin
                    if (bus.wr_ready && !last_plane) begin
                        plane_d = plane_q + 1'b1;
                    end else if (bus.wr_ready) begin
                        state_d = StWait;
                        if (c0_q < len0_q) begin
                            c0_d  = c0_q + 1'b1;
                            pos_d = pos_q + BDBANKA'(prec_q);
                        end else if (c1_q < len1_q) begin
                            c0_d  = '0;
                            c1_d  = c1_q + 1'b1;
                            pos_d = pos_q + stride0_q;
                        end else if (c2_q < len2_q) begin
                            c0_d  = '0;
                            c1_d  = '0;
                            c2_d  = c2_q + 1'b1;
                            pos_d = pos_q + stride1_q;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                        // Only reachable when the back-to-back window opens in_ready here.
                        if (bus.in_valid && bus.in_ready) begin
                            state_d = StWrite;
                            plane_d = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= StIdle;
            prec_q    <= '0;
            base_q    <= '0;
            stride0_q <= '0;
            stride1_q <= '0;
            len0_q    <= '0;
            len1_q    <= '0;
            len2_q    <= '0;
            c0_q      <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            pos_q     <= '0;
            plane_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prec_q    <= prec_d;
            base_q    <= base_d;
            stride0_q <= stride0_d;
            stride1_q <= stride1_d;
            len0_q    <= len0_d;
            len1_q    <= len1_d;
            len2_q    <= len2_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            pos_q     <= pos_d;
            plane_q   <= plane_d;
            done_q    <= done_d;
        end
    end

    // Write-side outputs are forced to zero outside WRITE so idle/reset values are clean.
    always_comb begin
        bus.wr_en    = (state_q == StWrite);
        bus.wr_addr  = '0;
        bus.wr_plane = '0;
        bus.omsb     = 1'b0;
        bus.olsb     = 1'b0;
        if (state_q == StWrite) begin
            bus.wr_addr  = base_q + pos_q + BDBANKA'(plane_q);
            bus.wr_plane = plane_q;
            bus.omsb     = (plane_q == '0);
            bus.olsb     = last_plane;
        end
        busy = (state_q != StIdle);
        done = done_q;
    end
endmodule

// File: tb/tb_outagu.sv
// Randomised self-checking bench for outagu against a closed-form address model.
module tb_outagu;
    localparam int BPREC    = 6;
    localparam int BDBANKA  = 15;
    localparam int BWLENGTH = 8;
    localparam int AMASK    = (1 << BDBANKA) - 1;

    logic                clk   = 1'b0;
    logic                clr_n = 1'b1;
    logic                start = 1'b0;
    logic [BPREC-1:0]    cfg_prec = '0;
    logic [BDBANKA-1:0]  cfg_base = '0, cfg_s0 = '0, cfg_s1 = '0;
    logic [BWLENGTH-1:0] cfg_l0 = '0, cfg_l1 = '0, cfg_l2 = '0;
    logic                busy, done;

    outagu_if #(.BPREC(BPREC), .BDBANKA(BDBANKA)) bus ();

    outagu #(.BPREC(BPREC), .BDBANKA(BDBANKA), .BWLENGTH(BWLENGTH)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .oprecision(cfg_prec),
        .obaseaddr (cfg_base),
        .ostride0  (cfg_s0),
        .ostride1  (cfg_s1),
        .olength0  (cfg_l0),
        .olength1  (cfg_l1),
        .olength2  (cfg_l2),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int obs_addr[$], obs_plane[$], obs_msb[$], obs_lsb[$], obs_cyc[$], obs_rdy[$];
    int stall_addr_q[$], stall_plane_q[$];
    int exp_addr[$], exp_plane[$], exp_msb[$], exp_lsb[$];
    int done_cnt, done_cyc, busy_at_done, done_after, busy_after;
    bit timed_out;

    // Position of vector (c0,c1,c2) in closed form; planes are consecutive words.
    function automatic void build_expected(input int prec_in, input int base, input int s0,
                                           input int s1, input int l0, input int l1,
                                           input int l2, input bit append);
        longint p, row, blk, pos;
        if (!append) begin
            exp_addr.delete(); exp_plane.delete(); exp_msb.delete(); exp_lsb.delete();
        end
        p   = (prec_in == 0) ? 1 : prec_in;
        row = l0 * p + s0;
        blk = l1 * row + l0 * p + s1;
        for (int c2 = 0; c2 <= l2; c2++)
            for (int c1 = 0; c1 <= l1; c1++)
                for (int c0 = 0; c0 <= l0; c0++) begin
                    pos = c0 * p + c1 * row + c2 * blk;
                    for (int pl = 0; pl < p; pl++) begin
                        exp_addr.push_back(int'((base + pos + pl) & AMASK));
                        exp_plane.push_back(pl);
                        exp_msb.push_back(pl == 0);
                        exp_lsb.push_back(pl == p - 1);
                    end
                end
    endfunction

    function automatic void set_cfg(input int prec, input int base, input int s0, input int s1,
                                    input int l0, input int l1, input int l2);
        cfg_prec = BPREC'(prec);
        cfg_base = BDBANKA'(base);
        cfg_s0   = BDBANKA'(s0);
        cfg_s1   = BDBANKA'(s1);
        cfg_l0   = BWLENGTH'(l0);
        cfg_l1   = BWLENGTH'(l1);
        cfg_l2   = BWLENGTH'(l2);
    endfunction

    // Runs one job and records what the DUT did; the calling test judges it.
    task automatic drive_job(input int stall_pct, input int valid_pct, input int stall_at,
                             input int stall_len, input int abort_after, input int abort_base,
                             input int max_cycles);
        int  cyc;
        int  stall_left;
        bit  aborted;
        bit  finished;
        obs_addr.delete(); obs_plane.delete(); obs_msb.delete(); obs_lsb.delete();
        obs_cyc.delete(); obs_rdy.delete(); stall_addr_q.delete(); stall_plane_q.delete();
        done_cnt = 0; done_cyc = -1; busy_at_done = -1;
        cyc = 0; stall_left = stall_len; aborted = 0; finished = 0;
        @(posedge clk); #1;
        start = 1'b1; bus.in_valid = 1'b0; bus.wr_ready = 1'b0;
        while (!finished && cyc < max_cycles) begin
            @(negedge clk);
            if (bus.wr_en && bus.wr_ready) begin
                obs_addr.push_back(int'(bus.wr_addr));
                obs_plane.push_back(int'(bus.wr_plane));
                obs_msb.push_back(int'(bus.omsb));
                obs_lsb.push_back(int'(bus.olsb));
                obs_cyc.push_back(cyc);
                obs_rdy.push_back(int'(bus.in_ready));
            end
            if (bus.wr_en && !bus.wr_ready) begin
                stall_addr_q.push_back(int'(bus.wr_addr));
                stall_plane_q.push_back(int'(bus.wr_plane));
            end
            if (done) begin
                done_cnt++; done_cyc = cyc; busy_at_done = int'(busy); finished = 1;
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            bus.in_valid = ($urandom_range(0, 99) < valid_pct);
            if (abort_after >= 0 && !aborted && obs_addr.size() == abort_after) begin
                start = 1'b1; cfg_base = abort_base[BDBANKA-1:0];
                bus.wr_ready = 1'b0; aborted = 1;
            end else if (stall_left > 0 && bus.wr_en && int'(bus.wr_addr) == stall_at) begin
                bus.wr_ready = 1'b0; stall_left--;
            end else begin
                bus.wr_ready = ($urandom_range(0, 99) >= stall_pct);
            end
        end
        timed_out = !finished;
        @(negedge clk);
        done_after = int'(done); busy_after = int'(busy);
        bus.in_valid = 1'b0; bus.wr_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 clr_n = 1'b0;
        #1;
        checks++;
        if ({bus.wr_en, busy, bus.in_ready, done} !== 4'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b want 0000",
                                     {bus.wr_en, busy, bus.in_ready, done}); end
        checks++;
        if (bus.wr_addr !== '0 || bus.wr_plane !== '0 || bus.omsb !== 1'b0 || bus.olsb !== 1'b0)
            begin errors++; $display("FAIL reset_bus: addr %0d plane %0d msb %b lsb %b want 0",
                                     bus.wr_addr, bus.wr_plane, bus.omsb, bus.olsb); end
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.wr_en !== 1'b0)
            begin errors++; $display("FAIL reset_idle: busy %b wr_en %b want 0 0",
                                     busy, bus.wr_en); end
    endtask

    task automatic test_basic();
        int lit[8] = '{100, 101, 102, 103, 112, 113, 114, 115};
        int msb[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        set_cfg(2, 100, 10, 0, 1, 1, 0);
        drive_job(0, 100, -1, 0, -1, 0, 200);
        checks++;
        if (timed_out || obs_addr.size() != 8)
            begin errors++; $display("FAIL basic_count: writes %0d timeout %0d want 8 0",
                                     obs_addr.size(), timed_out); end
        for (int i = 0; i < 8 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != lit[i] || obs_msb[i] != msb[i])
                begin errors++; $display("FAIL basic_addr[%0d]: addr %0d msb %0d want %0d %0d",
                                         i, obs_addr[i], obs_msb[i], lit[i], msb[i]); end
        end
        if (obs_cyc.size() == 8) begin
            checks++;
            if (done_cyc != obs_cyc[7] + 1 || busy_at_done != 0 || done_after != 0)
                begin errors++; $display("FAIL basic_done: cyc %0d busy %0d after %0d want %0d 0 0",
                                         done_cyc, busy_at_done, done_after, obs_cyc[7] + 1); end
`ifdef OUTAGU_BACK2BACK_EN
            checks++;
            if (obs_cyc[7] - obs_cyc[0] != 7)
                begin errors++; $display("FAIL b2b_span: %0d cycles want 7",
                                         obs_cyc[7] - obs_cyc[0]); end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_rdy[i] != ((i == 1 || i == 3 || i == 5) ? 1 : 0))
                    begin errors++; $display("FAIL b2b_ready[%0d]: got %0d at addr %0d",
                                             i, obs_rdy[i], obs_addr[i]); end
            end
`else
            checks++;
            if (obs_cyc[2] - obs_cyc[0] != 3 || obs_cyc[7] - obs_cyc[0] != 10)
                begin errors++; $display("FAIL basic_rate: gaps %0d %0d want 3 10",
                                         obs_cyc[2] - obs_cyc[0], obs_cyc[7] - obs_cyc[0]); end
            checks++;
            if (obs_rdy.sum() != 0)
                begin errors++; $display("FAIL basic_ready: in_ready during writes %0d want 0",
                                         obs_rdy.sum()); end
`endif
        end
    endtask

    task automatic test_stall();
        set_cfg(2, 100, 10, 0, 1, 1, 0);
        build_expected(2, 100, 10, 0, 1, 1, 0, 0);
        drive_job(0, 100, 101, 3, -1, 0, 200);
        checks++;
        if (stall_addr_q.size() != 3)
            begin errors++; $display("FAIL stall_len: held %0d want 3", stall_addr_q.size()); end
        foreach (stall_addr_q[i]) begin
            checks++;
            if (stall_addr_q[i] != 101 || stall_plane_q[i] != 1)
                begin errors++; $display("FAIL stall_hold[%0d]: addr %0d plane %0d want 101 1",
                                         i, stall_addr_q[i], stall_plane_q[i]); end
        end
        checks++;
        if (timed_out || obs_addr != exp_addr)
            begin errors++; $display("FAIL stall_seq: writes %0d want %0d timeout %0d",
                                     obs_addr.size(), exp_addr.size(), timed_out); end
    endtask

    task automatic test_wrap();
        int lit[3] = '{32766, 32767, 0};
        set_cfg(1, 32766, 0, 1, 0, 0, 2);
        drive_job(0, 100, -1, 0, -1, 0, 100);
        checks++;
        if (timed_out || obs_addr.size() != 3 || done_cnt != 1)
            begin errors++; $display("FAIL wrap_count: writes %0d done %0d want 3 1",
                                     obs_addr.size(), done_cnt); end
        for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != lit[i] || obs_msb[i] != 1 || obs_lsb[i] != 1)
                begin errors++; $display("FAIL wrap[%0d]: addr %0d msb %0d lsb %0d want %0d 1 1",
                                         i, obs_addr[i], obs_msb[i], obs_lsb[i], lit[i]); end
        end
    endtask

    task automatic test_zero_prec();
        set_cfg(0, 5, 0, 0, 0, 0, 0);
        drive_job(0, 100, -1, 0, -1, 0, 50);
        checks++;
        if (timed_out || obs_addr.size() != 1)
            begin errors++; $display("FAIL zprec_count: writes %0d want 1", obs_addr.size()); end
        else begin
            checks++;
            if (obs_addr[0] != 5 || obs_plane[0] != 0 || obs_msb[0] != 1 || obs_lsb[0] != 1)
                begin errors++; $display("FAIL zprec_write: addr %0d plane %0d want 5 0",
                                         obs_addr[0], obs_plane[0]); end
        end
    endtask

    task automatic test_abort();
        set_cfg(2, 100, 10, 0, 1, 1, 0);
        build_expected(2, 100, 10, 0, 1, 1, 0, 0);
        while (exp_addr.size() > 3) void'(exp_addr.pop_back());
        build_expected(2, 200, 10, 0, 1, 1, 0, 1);
        drive_job(0, 100, -1, 0, 3, 200, 300);
        checks++;
        if (timed_out || done_cnt != 1 || obs_addr.size() != 11)
            begin errors++; $display("FAIL abort_count: writes %0d done %0d want 11 1",
                                     obs_addr.size(), done_cnt); end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != exp_addr[i])
                begin errors++; $display("FAIL abort_addr[%0d]: got %0d want %0d",
                                         i, obs_addr[i], exp_addr[i]); end
        end
    endtask

    task automatic test_random();
        int p, b, s0, s1, l0, l1, l2;
        for (int t = 0; t < 12; t++) begin
            p  = $urandom_range(0, 4);
            b  = $urandom & AMASK;
            s0 = $urandom & AMASK;
            s1 = $urandom & AMASK;
            l0 = $urandom_range(0, 2);
            l1 = $urandom_range(0, 2);
            l2 = $urandom_range(0, 2);
            set_cfg(p, b, s0, s1, l0, l1, l2);
            build_expected(p, b, s0, s1, l0, l1, l2, 0);
            drive_job(30, 70, -1, 0, -1, 0, 3000);
            checks++;
            if (timed_out || obs_addr != exp_addr || obs_plane != exp_plane ||
                obs_msb != exp_msb || obs_lsb != exp_lsb)
                begin errors++; $display("FAIL rand[%0d]: writes %0d want %0d timeout %0d",
                                         t, obs_addr.size(), exp_addr.size(), timed_out); end
            checks++;
            if (obs_cyc.size() == 0 || done_cyc != obs_cyc[obs_cyc.size() - 1] + 1 ||
                busy_at_done != 0)
                begin errors++; $display("FAIL rand_done[%0d]: done cyc %0d busy %0d",
                                         t, done_cyc, busy_at_done); end
        end
    endtask

    task automatic test_async_reset();
        int n;
        set_cfg(2, 100, 10, 0, 1, 1, 0);
        @(posedge clk); #1;
        start = 1'b1; bus.in_valid = 1'b1; bus.wr_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!bus.wr_en && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (bus.wr_en !== 1'b1)
            begin errors++; $display("FAIL arst_setup: wr_en %b want 1", bus.wr_en); end
        #2 clr_n = 1'b0;
        #1;
        checks++;
        if ({bus.wr_en, busy, bus.in_ready} !== 3'b000)
            begin errors++; $display("FAIL arst_now: wr_en/busy/in_ready %b want 000",
                                     {bus.wr_en, busy, bus.in_ready}); end
        @(negedge clk); #1 clr_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.wr_en !== 1'b0)
            begin errors++; $display("FAIL arst_idle: busy %b wr_en %b want 0 0",
                                     busy, bus.wr_en); end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_prec();
        test_abort();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
